// File: rtl/alu_opsel_pkg.sv
// alu_opsel_pkg
// Shared types for the ALU operation-select controller:
//   opcode_e  - 3-bit operation codes (110/111 are not enumerated: illegal)
//   state_e   - controller FSM states
//   SEL_W     - width of the one-hot result select
//   sel_t     - one-hot select vector, bit 0 = AND ... bit 5 = REG
//   op_is_illegal() - true for the two unused opcode encodings
package alu_opsel_pkg;

  localparam int SEL_W = 6;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_NOT = 3'b010,
    OP_XOR = 3'b011,
    OP_SUM = 3'b100,
    OP_REG = 3'b101
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  typedef logic [SEL_W-1:0] sel_t;

  function automatic logic op_is_illegal(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/alu_opsel_ctrl_if.sv
// alu_opsel_ctrl_if
// Bundles the opcode handshake and the result-select outputs of the
// controller.
//   master : drives in_valid, opcode, flush; observes everything else
//   slave  : the controller itself
// Signals: in_valid/in_ready (opcode handshake), opcode[2:0], flush,
//   aop/bop/cop/dop/eop/fop (one-hot selects), reg_we, done, err.
interface alu_opsel_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] opcode;
  logic       flush;
  logic       aop;
  logic       bop;
  logic       cop;
  logic       dop;
  logic       eop;
  logic       fop;
  logic       reg_we;
  logic       done;
  logic       err;

  modport master (
    output in_valid, opcode, flush,
    input  in_ready, aop, bop, cop, dop, eop, fop, reg_we, done, err
  );

  modport slave (
    input  in_valid, opcode, flush,
    output in_ready, aop, bop, cop, dop, eop, fop, reg_we, done, err
  );
endinterface

// File: rtl/alu_opsel_dec.sv
// alu_opsel_dec
// Purely combinational decode of the latched opcode into the one-hot
// result select. Unused encodings give an all-zero select and raise
// illegal; the controller FSM decides when the select is visible.
// Ports:
//   op      in  [2:0] latched opcode
//   sel     out sel_t one-hot select (bit 0 = AND ... bit 5 = REG)
//   illegal out       opcode is 110 or 111
module alu_opsel_dec
  import alu_opsel_pkg::*;
(
  input  logic [2:0] op,
  output sel_t       sel,
  output logic       illegal
);

  always_comb begin
    sel     = '0;
    illegal = 1'b0;
    case (op)
      OP_AND:  sel[0] = 1'b1;
      OP_OR:   sel[1] = 1'b1;
      OP_NOT:  sel[2] = 1'b1;
      OP_XOR:  sel[3] = 1'b1;
      OP_SUM:  sel[4] = 1'b1;
      OP_REG:  sel[5] = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_opsel_ctrl.sv
// alu_opsel_ctrl
// Accepts an opcode over a valid/ready handshake, holds the decoded
// one-hot result select for EXEC_CYCLES cycles plus one write-back cycle,
// and pulses reg_we/done in the write-back cycle. flush aborts an
// operation in flight without a write.
// Ports:
//   clk    in  single clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    alu_opsel_ctrl_if.slave (handshake, selects, reg_we, done, err)
// Parameter:
//   EXEC_CYCLES  cycles the select is held before write-back (1..8)
// Build option:
//   ALU_OPSEL_ILLEGAL_ERR_EN  when defined, an illegal opcode skips
//   EXEC/WB and pulses err for one cycle; otherwise it runs as a NOP
//   (no select, no reg_we, done still pulses) and err is tied low.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for opcode; in_ready high unless flush
// ST_EXEC | select held, down-counter running from EXEC_CYCLES-1 to 0
// ST_WB   | select held, reg_we/done (or err) pulse, back to IDLE next
module alu_opsel_ctrl
  import alu_opsel_pkg::*;
#(
  parameter int EXEC_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_opsel_ctrl_if.slave  bus
);

  localparam logic [2:0] CNT_LOAD = 3'(EXEC_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] op_q, op_d;
  sel_t       dec_sel;
  sel_t       sel;
  logic       dec_illegal;
  logic       handshake;
  logic       in_wb;

  alu_opsel_dec u_dec (
    .op      (op_q),
    .sel     (dec_sel),
    .illegal (dec_illegal)
  );

  assign bus.in_ready = (state_q == ST_IDLE) & ~bus.flush;
  assign handshake    = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      op_q    <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          op_d  = bus.opcode;
          cnt_d = CNT_LOAD;
`ifdef ALU_OPSEL_ILLEGAL_ERR_EN
          // Illegal opcodes go straight to the single WB cycle, which
          // then reports err instead of a write.
          state_d = op_is_illegal(bus.opcode) ? ST_WB : ST_EXEC;
`else
          state_d = ST_EXEC;
`endif
        end
      end
      ST_EXEC: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
        end else if (cnt_q == 3'd0) begin
          state_d = ST_WB;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Selects come straight from the decoder of the latched opcode, so
  // opcode changes on the bus after the handshake cannot disturb them.
  assign sel   = (state_q != ST_IDLE) ? dec_sel : '0;
  assign in_wb = (state_q == ST_WB);

  assign bus.aop = sel[0];
  assign bus.bop = sel[1];
  assign bus.cop = sel[2];
  assign bus.dop = sel[3];
  assign bus.eop = sel[4];
  assign bus.fop = sel[5];

  assign bus.reg_we = in_wb & ~dec_illegal;

`ifdef ALU_OPSEL_ILLEGAL_ERR_EN
  assign bus.done = in_wb & ~dec_illegal;
  assign bus.err  = in_wb & dec_illegal;
`else
  assign bus.done = in_wb;
  assign bus.err  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_opsel_ctrl.sv
// tb_alu_opsel_ctrl
// Directed test of alu_opsel_ctrl with two instances: EXEC_CYCLES=1 and
// EXEC_CYCLES=4. Inputs change 1 ns after a rising edge; outputs are
// sampled at that point, i.e. in the cycle that edge started.
module tb_alu_opsel_ctrl;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  alu_opsel_ctrl_if b1 ();
  alu_opsel_ctrl_if b4 ();

  alu_opsel_ctrl #(.EXEC_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  alu_opsel_ctrl #(.EXEC_CYCLES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));

  logic [5:0] s1, s4;
  assign s1 = {b1.fop, b1.eop, b1.dop, b1.cop, b1.bop, b1.aop};
  assign s4 = {b4.fop, b4.eop, b4.dop, b4.cop, b4.bop, b4.aop};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int we_cnt;
    rst_n = 1'b0;
    b1.in_valid = 1'b0; b1.opcode = 3'd0; b1.flush = 1'b0;
    b4.in_valid = 1'b0; b4.opcode = 3'd0; b4.flush = 1'b0;
    #12;
    check("rst_sel1", 32'(s1), 0);
    check("rst_sel4", 32'(s4), 0);
    check("rst_we1", 32'(b1.reg_we), 0);
    check("rst_done1", 32'(b1.done), 0);
    check("rst_err1", 32'(b1.err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("idle_rdy1", 32'(b1.in_ready), 1);
    check("idle_rdy4", 32'(b4.in_ready), 1);

    // single op 100, EXEC_CYCLES=1
    b1.in_valid = 1'b1; b1.opcode = 3'b100;
    step();
    b1.in_valid = 1'b0;
    check("sum_c1_sel", 32'(s1), 32'h10);
    check("sum_c1_we", 32'(b1.reg_we), 0);
    check("sum_c1_done", 32'(b1.done), 0);
    check("sum_c1_rdy", 32'(b1.in_ready), 0);
    step();
    check("sum_c2_sel", 32'(s1), 32'h10);
    check("sum_c2_we", 32'(b1.reg_we), 1);
    check("sum_c2_done", 32'(b1.done), 1);
    step();
    check("sum_c3_sel", 32'(s1), 0);
    check("sum_c3_rdy", 32'(b1.in_ready), 1);
    check("sum_c3_we", 32'(b1.reg_we), 0);

    // back-to-back 000..101 with in_valid held; opcode scrambled in EXEC/WB
    we_cnt = 0;
    b1.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b1.opcode = 3'(i);
      step();
      check("b2b_exec_sel", 32'(s1), 32'(1 << i));
      check("b2b_exec_we", 32'(b1.reg_we), 0);
      check("b2b_onehot", 32'($countones(s1) <= 1), 1);
      b1.opcode = 3'(7 - i);
      step();
      check("b2b_wb_sel", 32'(s1), 32'(1 << i));
      check("b2b_onehot", 32'($countones(s1) <= 1), 1);
      if (b1.reg_we) we_cnt++;
      step();
      check("b2b_idle_sel", 32'(s1), 0);
      check("b2b_idle_rdy", 32'(b1.in_ready), 1);
      if (b1.reg_we) we_cnt++;
    end
    b1.in_valid = 1'b0;
    check("b2b_we_count", 32'(we_cnt), 6);

    // flush in WB does not kill that cycle's reg_we
    b1.in_valid = 1'b1; b1.opcode = 3'b001;
    step();
    b1.in_valid = 1'b0;
    check("wbfl_exec_sel", 32'(s1), 32'h02);
    step();
    b1.flush = 1'b1;
    #1;
    check("wbfl_we", 32'(b1.reg_we), 1);
    check("wbfl_sel", 32'(s1), 32'h02);
    step();
    check("wbfl_after_sel", 32'(s1), 0);
    check("wbfl_after_we", 32'(b1.reg_we), 0);
    b1.flush = 1'b0;
    #1;
    check("wbfl_rdy", 32'(b1.in_ready), 1);

    // EXEC_CYCLES=4, opcode 011, flush in 2nd EXEC cycle
    b4.in_valid = 1'b1; b4.opcode = 3'b011;
    step();
    b4.in_valid = 1'b0; b4.opcode = 3'b000;
    check("fl_e1_sel", 32'(s4), 32'h08);
    step();
    check("fl_e2_sel", 32'(s4), 32'h08);
    b4.flush = 1'b1;
    step();
    check("fl_sel", 32'(s4), 0);
    check("fl_we", 32'(b4.reg_we), 0);
    check("fl_done", 32'(b4.done), 0);
    check("fl_rdy_flush_hi", 32'(b4.in_ready), 0);
    b4.flush = 1'b0;
    #1;
    check("fl_rdy", 32'(b4.in_ready), 1);
    for (int k = 0; k < 6; k++) begin
      step();
      check("fl_quiet", 32'({s4, b4.reg_we, b4.done}), 0);
    end

    // illegal opcode 110 on EXEC_CYCLES=4
    b4.in_valid = 1'b1; b4.opcode = 3'b110;
    step();
    b4.in_valid = 1'b0;
`ifdef ALU_OPSEL_ILLEGAL_ERR_EN
    check("ill_err", 32'(b4.err), 1);
    check("ill_sel", 32'(s4), 0);
    check("ill_we", 32'(b4.reg_we), 0);
    check("ill_done", 32'(b4.done), 0);
    step();
    check("ill_err_off", 32'(b4.err), 0);
    check("ill_rdy", 32'(b4.in_ready), 1);
    check("ill_done2", 32'(b4.done), 0);
`else
    for (int k = 0; k < 4; k++) begin
      check("nop_exec", 32'({s4, b4.done, b4.err, b4.reg_we}), 0);
      check("nop_exec_rdy", 32'(b4.in_ready), 0);
      step();
    end
    check("nop_wb_done", 32'(b4.done), 1);
    check("nop_wb_we", 32'(b4.reg_we), 0);
    check("nop_wb_sel", 32'(s4), 0);
    check("nop_wb_err", 32'(b4.err), 0);
    step();
    check("nop_rdy", 32'(b4.in_ready), 1);
    check("nop_done_off", 32'(b4.done), 0);
`endif

    // reset during EXEC of opcode 101
    b4.in_valid = 1'b1; b4.opcode = 3'b101;
    step();
    b4.in_valid = 1'b0;
    check("rst_op_e1", 32'(s4), 32'h20);
    step();
    check("rst_op_e2", 32'(s4), 32'h20);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_op_sel", 32'(s4), 0);
    check("rst_op_we", 32'(b4.reg_we), 0);
    step();
    check("rst_hold_we", 32'(b4.reg_we), 0);
    @(negedge clk);
    rst_n = 1'b1;
    b4.in_valid = 1'b1; b4.opcode = 3'b000;
    step();
    b4.in_valid = 1'b0;
    check("rst_rel_hs", 32'(s4), 32'h01);
    check("rst_rel_we", 32'(b4.reg_we), 0);
    for (int k = 0; k < 5; k++) step();
    check("rst_rel_idle", 32'(b4.in_ready), 1);

    // flush and in_valid together in IDLE
    b1.flush = 1'b1; b1.in_valid = 1'b1; b1.opcode = 3'b000;
    #1;
    check("fv_rdy", 32'(b1.in_ready), 0);
    step();
    check("fv_sel", 32'(s1), 0);
    check("fv_rdy2", 32'(b1.in_ready), 0);
    b1.flush = 1'b0; b1.in_valid = 1'b0;
    #1;
    check("fv_rdy_back", 32'(b1.in_ready), 1);
    step();
    check("fv_sel2", 32'(s1), 0);
    check("fv_done", 32'(b1.done), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_opsel_ctrl.md
ALU_OPSEL_CTRL -- requirements
Module: alu_opsel_ctrl

Interface
REQ-001 SHALL have parameter: EXEC_CYCLES, default 1, number of cycles the decoded select is held before write-back (legal 1..8).
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  opcode offered.
- in_ready  output  1  controller can accept opcode.
- opcode  input  3  operation code.
- flush  input  1  synchronous abort of current operation.
- aop, bop, cop, dop, eop, fop  output  1 each  one-hot result selects (AND, OR, NOT, XOR, SUM, REG).
- reg_we  output  1  result register write enable, one-cycle pulse.
- done  output  1  operation complete, one-cycle pulse.
- err  output  1  illegal-opcode pulse (present only with ALU_OPSEL_ILLEGAL_ERR_EN; tied 0 otherwise).

Function
REQ-003 SHALL decode opcode: 000->aop, 001->bop, 010->cop, 011->dop, 100->eop, 101->fop; 110 and 111 illegal.
REQ-004 SHALL implement FSM states IDLE, EXEC, WB.
REQ-005 SHALL assert in_ready only in IDLE with flush low; handshake = in_valid & in_ready at rising edge; opcode latched on that edge.
REQ-006 IDLE -> EXEC on handshake; EXEC held exactly EXEC_CYCLES cycles (down-counter, 3 bits, loaded EXEC_CYCLES-1); EXEC -> WB when counter is 0; WB -> IDLE unconditionally after one cycle.
REQ-007 Selected output SHALL be high in every EXEC and WB cycle of the operation, all selects low in IDLE; at most one select high in any cycle.
REQ-008 reg_we and done SHALL both pulse high for the single WB cycle only.
REQ-009 Latency: handshake at edge N -> select high cycles N+1 .. N+EXEC_CYCLES+1; reg_we/done in cycle N+EXEC_CYCLES+1; in_ready high again in cycle N+EXEC_CYCLES+2 (back-to-back throughput one op per EXEC_CYCLES+2 cycles).
REQ-010 in_valid and opcode SHALL be ignored outside IDLE; opcode changes during EXEC/WB do not alter selects.
REQ-011 flush high in EXEC or WB SHALL force IDLE at next edge; all selects, reg_we, done low from that edge; no reg_we for the aborted op; flush in WB cycle does not suppress that cycle's already-asserted reg_we.
REQ-012 flush and in_valid together in IDLE: flush wins, no handshake.

Reset
REQ-013 rst_n low SHALL asynchronously force IDLE, counter 0, latched opcode 000; outputs: in_ready 1 after reset release, all selects 0, reg_we 0, done 0, err 0.
REQ-014 Reset asserted mid-operation SHALL abort without reg_we; first handshake possible on first rising edge after release.

Configuration
REQ-015 Macro ALU_OPSEL_ILLEGAL_ERR_EN defined: illegal opcode accepted, no EXEC/WB, err pulses one cycle (cycle N+1), no select, no reg_we, no done, back to IDLE at N+2.
REQ-016 Macro undefined: illegal opcode runs as NOP through EXEC/WB with normal timing, all selects 0, reg_we 0, done pulses; err constant 0.

Structure
REQ-017 Package alu_opsel_pkg SHALL hold opcode enum (OP_AND..OP_REG), FSM state enum, SEL_W=6 constant, and one-hot select typedef.
REQ-018 Combinational sub-module alu_opsel_dec SHALL map latched opcode to the 6-bit one-hot select plus illegal flag; FSM gates its output.

Verification
REQ-019 Reset then opcode 100, EXEC_CYCLES=1 -> eop high 2 cycles, reg_we/done in 2nd cycle, in_ready back in 3rd.
REQ-020 Back-to-back 000,001,010,011,100,101 with in_valid held -> aop..fop each in turn, 6 reg_we pulses, never two selects high.
REQ-021 EXEC_CYCLES=4, opcode 011, flush in 2nd EXEC cycle -> dop drops next edge, no reg_we, no done, in_ready high.
REQ-022 Opcode 110 with macro -> err one cycle, no reg_we/done; without macro -> selects 0, done after EXEC_CYCLES+1, reg_we 0.
REQ-023 rst_n low during EXEC of opcode 101 -> fop low immediately, no reg_we; after release opcode 000 handshakes on first edge.
REQ-024 flush and in_valid high together in IDLE -> no handshake, state stays IDLE, all selects 0.
